// File: rtl/clos_cm_pkg.sv
// clos_cm_pkg: shared constants and helpers for the SDM-Clos central-module
// switch (clos_cm_obuf) and its output FIFO (clos_obuf_fifo).
//   PCNT_W : width of the per-output packet counters.
//   clog2  : ceiling log2, usable in parameter expressions.
// The flit struct depends on the data width, so flit_t is declared inside
// clos_cm_obuf where DW is known.
package clos_cm_pkg;

  localparam int unsigned PCNT_W = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/clos_obuf_fifo.sv
// clos_obuf_fifo: per-output flit buffer, W bits wide and DEPTH deep
// (DEPTH a power of two, at least 2).
//   clk, rst_n : clock, asynchronous active-low reset
//   i_wen      : write request (ignored while full)
//   i_wdat     : write data
//   o_full     : buffer full, from the registered count
//   i_ren      : downstream ready (a read happens when o_vld is also high)
//   o_vld      : buffer not empty
//   o_rdat     : head entry; holds the last read entry while empty
module clos_obuf_fifo
  import clos_cm_pkg::*;
#(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wen,
  input  logic [W-1:0] i_wdat,
  output logic         o_full,
  input  logic         i_ren,
  output logic         o_vld,
  output logic [W-1:0] o_rdat
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_hold;
  logic          w_wr;
  logic          w_rd;

  assign o_full = (r_cnt == CW'(DEPTH));
  assign o_vld  = (r_cnt != '0);
  assign w_wr   = i_wen && !o_full;
  assign w_rd   = i_ren && o_vld;
  // While empty, present the most recently read entry rather than stale RAM.
  assign o_rdat = o_vld ? r_mem[r_rp] : r_hold;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_wdat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_hold <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) begin
        r_rp   <= r_rp + 1'b1;
        r_hold <= r_mem[r_rp];
      end
      if (w_wr && !w_rd)      r_cnt <= r_cnt + 1'b1;
      else if (!w_wr && w_rd) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/clos_cm.sv
// clos_cm_obuf: parametrised central-module switch with one FIFO per output.
// Wormhole switching: each output round-robin arbitrates among head flits
// and stays locked to the winner until its eof flit is written.
//   clk, rst_n      : clock, asynchronous active-low reset
//   di_dat/eof/vld  : KN input flit channels; di_rdy = accepted this cycle
//   di_dec          : one-hot route request per input (head flits only;
//                     lowest set bit wins)
//   do_dat/eof/vld  : KN output channels; do_rdy = downstream accepts
//   do_pcnt         : per-output eof counters, saturating (only when the
//                     macro CLOS_CM_STAT_EN is defined)
module clos_cm_obuf
  import clos_cm_pkg::*;
#(
  parameter int unsigned KN    = 5,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [KN-1:0][DW-1:0]  di_dat,
  input  logic [KN-1:0]          di_eof,
  input  logic [KN-1:0]          di_vld,
  output logic [KN-1:0]          di_rdy,
  input  logic [KN-1:0][KN-1:0]  di_dec,
  output logic [KN-1:0][DW-1:0]  do_dat,
  output logic [KN-1:0]          do_eof,
  output logic [KN-1:0]          do_vld,
  input  logic [KN-1:0]          do_rdy
`ifdef CLOS_CM_STAT_EN
  ,
  output logic [KN-1:0][PCNT_W-1:0] do_pcnt
`endif
);

  localparam int unsigned IW = (clog2(KN) > 0) ? clog2(KN) : 1;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          eof;
  } flit_t;

  logic [KN-1:0]         r_head;      // next flit on input i is a head flit
  logic [KN-1:0]         r_lock_vld;
  logic [KN-1:0][IW-1:0] r_lock_own;
  logic [KN-1:0][IW-1:0] r_rr;
  logic [KN-1:0]         w_full;
  logic [KN-1:0][KN-1:0] w_req;       // [output][input]
  logic [KN-1:0][KN-1:0] w_gnt;       // [output][input]
  logic [KN-1:0]         w_wen;
  logic [KN-1:0][IW-1:0] w_wsrc;
  flit_t [KN-1:0]        w_wdat;
  flit_t [KN-1:0]        w_rdat;

  // Route each input to exactly one output: the locked one if it owns a
  // lock, otherwise the lowest requested output when at a head flit.
  always_comb begin
    logic owned;
    logic found;
    w_req = '0;
    for (int unsigned i = 0; i < KN; i++) begin
      owned = 1'b0;
      for (int unsigned j = 0; j < KN; j++) begin
        if (r_lock_vld[j] && r_lock_own[j] == IW'(i)) begin
          w_req[j][i] = di_vld[i];
          owned       = 1'b1;
        end
      end
      found = 1'b0;
      if (!owned && r_head[i]) begin
        for (int unsigned j = 0; j < KN; j++) begin
          if (!found && di_dec[i][j]) begin
            w_req[j][i] = di_vld[i];
            found       = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    logic        found;
    int unsigned idx;
    w_gnt  = '0;
    w_wen  = '0;
    w_wsrc = '0;
    w_wdat = '0;
    for (int unsigned j = 0; j < KN; j++) begin
      found = 1'b0;
      for (int unsigned k = 0; k < KN; k++) begin
        if (r_lock_vld[j]) idx = k;
        else               idx = (32'(r_rr[j]) + k) % KN;
        if (!found && !w_full[j] && w_req[j][idx] &&
            (!r_lock_vld[j] || r_lock_own[j] == IW'(idx))) begin
          found         = 1'b1;
          w_gnt[j][idx] = 1'b1;
          w_wen[j]      = 1'b1;
          w_wsrc[j]     = IW'(idx);
          w_wdat[j].dat = di_dat[idx];
          w_wdat[j].eof = di_eof[idx];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < KN; i++) begin
      di_rdy[i] = 1'b0;
      for (int unsigned j = 0; j < KN; j++) di_rdy[i] = di_rdy[i] | w_gnt[j][i];
      di_rdy[i] = di_rdy[i] & rst_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '1;
      r_lock_vld <= '0;
      r_lock_own <= '0;
      r_rr       <= '0;
    end else begin
      for (int unsigned i = 0; i < KN; i++) begin
        if (di_vld[i] && di_rdy[i]) r_head[i] <= di_eof[i];
      end
      for (int unsigned j = 0; j < KN; j++) begin
        if (w_wen[j]) begin
          // A write into an unlocked output is always a head flit.
          if (w_wdat[j].eof) begin
            r_lock_vld[j] <= 1'b0;
          end else if (!r_lock_vld[j]) begin
            r_lock_vld[j] <= 1'b1;
            r_lock_own[j] <= w_wsrc[j];
          end
          if (!r_lock_vld[j])
            r_rr[j] <= (w_wsrc[j] == IW'(KN - 1)) ? '0 : w_wsrc[j] + 1'b1;
        end
      end
    end
  end

  for (genvar j = 0; j < KN; j++) begin : g_out
    clos_obuf_fifo #(
      .W     (DW + 1),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_wen  (w_wen[j]),
      .i_wdat (w_wdat[j]),
      .o_full (w_full[j]),
      .i_ren  (do_rdy[j]),
      .o_vld  (do_vld[j]),
      .o_rdat (w_rdat[j])
    );
    assign do_dat[j] = w_rdat[j].dat;
    assign do_eof[j] = w_rdat[j].eof;
  end

`ifdef CLOS_CM_STAT_EN
  logic [KN-1:0][PCNT_W-1:0] r_pcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
    end else begin
      for (int unsigned j = 0; j < KN; j++) begin
        if (do_vld[j] && do_rdy[j] && do_eof[j] && r_pcnt[j] != '1)
          r_pcnt[j] <= r_pcnt[j] + 1'b1;
      end
    end
  end

  assign do_pcnt = r_pcnt;
`endif

endmodule

// File: tb/tb_clos_cm_obuf.sv
// Scoreboard bench for clos_cm_obuf. Flit data carries the source input in
// its top three bits so the monitor can detect interleaved packets.
module tb_clos_cm_obuf;

  localparam int KN    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [KN-1:0][DW-1:0] di_dat;
  logic [KN-1:0]         di_eof;
  logic [KN-1:0]         di_vld;
  logic [KN-1:0]         di_rdy;
  logic [KN-1:0][KN-1:0] di_dec;
  logic [KN-1:0][DW-1:0] do_dat;
  logic [KN-1:0]         do_eof;
  logic [KN-1:0]         do_vld;
  logic [KN-1:0]         do_rdy;
`ifdef CLOS_CM_STAT_EN
  logic [KN-1:0][15:0]   do_pcnt;
`endif

  always #5 clk = ~clk;

  clos_cm_obuf #(.KN(KN), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .di_dat (di_dat),
    .di_eof (di_eof),
    .di_vld (di_vld),
    .di_rdy (di_rdy),
    .di_dec (di_dec),
    .do_dat (do_dat),
    .do_eof (do_eof),
    .do_vld (do_vld),
    .do_rdy (do_rdy)
`ifdef CLOS_CM_STAT_EN
    , .do_pcnt(do_pcnt)
`endif
  );

  typedef struct {
    logic [DW-1:0] dat;
    logic          eof;
    logic [KN-1:0] dec;
  } sflit_t;

  typedef struct {
    logic [DW-1:0] dat;
    logic          eof;
    int            cyc;
  } eflit_t;

  sflit_t inq  [KN][$];
  eflit_t expq [KN][$];
  int     accq [KN][$];
  int     acc_cyc [KN][$];
  eflit_t last_exp [KN];
  int     acc_cnt [KN];
  int     cur_dst [KN];
  bit     head_m  [KN];
  bit     in_pkt  [KN];
  int     cur_src [KN];
  int     pcnt_m  [KN];
  int     cyc = 0;
  int     total = 0;
  int     bad = 0;
  bit     drv_on = 0;
  bit     lat_chk = 0;
  bit     rand_rdy = 0;
  logic [KN-1:0] rdy_en = '1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic int lowbit(input logic [KN-1:0] d);
    for (int k = 0; k < KN; k++) if (d[k]) return k;
    return -1;
  endfunction

  function automatic int accq_at(input int j, input int k);
    if (k < accq[j].size()) return accq[j][k];
    return -1;
  endfunction

  function automatic bit idle();
    for (int i = 0; i < KN; i++) if (inq[i].size() != 0 || expq[i].size() != 0) return 0;
    return 1;
  endfunction

  // Packet of len flits from src to dst; head dec may carry extra higher
  // bits (lowest set bit decides), body dec is random noise.
  task automatic add_pkt(input int src, input int dst, input int len);
    sflit_t f;
    for (int n = 0; n < len; n++) begin
      f.dat = {3'(src), 5'($urandom)};
      f.eof = (n == len - 1);
      if (n == 0) begin
        f.dec = '0;
        f.dec[dst] = 1'b1;
        for (int k = dst + 1; k < KN; k++) if ($urandom_range(0, 1) == 1) f.dec[k] = 1'b1;
      end else begin
        f.dec = KN'($urandom);
      end
      inq[src].push_back(f);
    end
  endtask

  task automatic drain(input string nm);
    int c;
    c = 0;
    while (c < 3000 && !idle()) begin
      @(posedge clk);
      c++;
    end
    chk(nm, 64'(idle()), 64'd1);
    repeat (2) @(posedge clk);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < KN; i++) begin
      accq[i].delete();
      acc_cyc[i].delete();
    end
  endtask

  // Driver: present queue heads after each rising edge, record accepted
  // flits mid-cycle (the transfer happens at the next rising edge).
  initial begin
    sflit_t f;
    forever begin
      @(posedge clk);
      #1;
      if (drv_on) begin
        for (int i = 0; i < KN; i++) begin
          if (rst_n && inq[i].size() > 0) begin
            di_vld[i] = 1'b1;
            di_dat[i] = inq[i][0].dat;
            di_eof[i] = inq[i][0].eof;
            di_dec[i] = inq[i][0].dec;
          end else begin
            di_vld[i] = 1'b0;
          end
        end
        for (int j = 0; j < KN; j++)
          do_rdy[j] = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_en[j];
        @(negedge clk);
        if (rst_n) begin
          for (int i = 0; i < KN; i++) begin
            if (di_vld[i] && di_rdy[i]) begin
              f = inq[i].pop_front();
              if (head_m[i]) begin
                cur_dst[i] = lowbit(f.dec);
                accq[cur_dst[i]].push_back(i);
              end
              expq[cur_dst[i]].push_back('{dat: f.dat, eof: f.eof, cyc: cyc});
              acc_cyc[i].push_back(cyc);
              acc_cnt[i]++;
              head_m[i] = f.eof;
            end
          end
        end
      end
    end
  end

  // Monitor: compare every output transfer with the scoreboard.
  initial begin
    eflit_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int j = 0; j < KN; j++) begin
          if (do_vld[j] && do_rdy[j]) begin
            if (expq[j].size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_out[%0d]: got dat=%0h expected no flit", j, do_dat[j]);
            end else begin
              e = expq[j].pop_front();
              last_exp[j] = e;
              chk($sformatf("out_dat[%0d]", j), 64'(do_dat[j]), 64'(e.dat));
              chk($sformatf("out_eof[%0d]", j), 64'(do_eof[j]), 64'(e.eof));
              if (lat_chk) chk($sformatf("latency[%0d]", j), 64'(cyc - e.cyc), 64'd1);
              if (e.eof) pcnt_m[j]++;
            end
            if (in_pkt[j]) chk($sformatf("no_interleave[%0d]", j), 64'(do_dat[j][DW-1:DW-3]), 64'(cur_src[j]));
            cur_src[j] = int'(do_dat[j][DW-1:DW-3]);
            in_pkt[j]  = !do_eof[j];
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int span;
    for (int i = 0; i < KN; i++) head_m[i] = 1;
    rst_n  = 1'b0;
    di_vld = '1;
    di_dat = '0;
    di_eof = '0;
    di_dec = '1;
    do_rdy = '1;
    #12;
    chk("rst_do_vld", 64'(do_vld), 64'd0);
    chk("rst_do_dat", 64'(do_dat), 64'd0);
    chk("rst_do_eof", 64'(do_eof), 64'd0);
    chk("rst_di_rdy", 64'(di_rdy), 64'd0);
    di_vld = '0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    drv_on = 1;

    // single path in0 -> out2, then rr_ptr[2]=1 makes in1 win over in0
    lat_chk = 1;
    add_pkt(0, 2, 3);
    drain("single_drain");
    chk("single_heads", 64'(accq[2].size()), 64'd1);
    chk("hold_vld", 64'(do_vld[2]), 64'd0);
    chk("hold_dat", 64'(do_dat[2]), 64'(last_exp[2].dat));
    chk("hold_eof", 64'(do_eof[2]), 64'd1);
    clear_logs();
    add_pkt(0, 2, 2);
    add_pkt(1, 2, 2);
    drain("rr_drain");
    chk("rr_first", 64'(accq_at(2, 0)), 64'd1);
    chk("rr_second", 64'(accq_at(2, 1)), 64'd0);

    // contention on out4 with rr_ptr[4]=0
    clear_logs();
    add_pkt(1, 4, 2);
    add_pkt(3, 4, 2);
    drain("cont_drain");
    chk("cont_first", 64'(accq_at(4, 0)), 64'd1);
    chk("cont_second", 64'(accq_at(4, 1)), 64'd3);

    // backpressure on out0
    lat_chk = 0;
    rdy_en[0] = 1'b0;
    base = acc_cnt[2];
    add_pkt(2, 0, 8);
    repeat (12) @(posedge clk);
    #2;
    chk("bp_count", 64'(acc_cnt[2] - base), 64'(DEPTH));
    chk("bp_stall", 64'(di_rdy[2]), 64'd0);
    chk("bp_out_vld", 64'(do_vld[0]), 64'd1);
    rdy_en[0] = 1'b1;
    @(posedge clk);
    #2;
    chk("bp_full_rw", 64'(di_rdy[2]), 64'd0);
    @(posedge clk);
    #2;
    chk("bp_resume", 64'(di_rdy[2]), 64'd1);
    drain("bp_drain");
    chk("bp_total", 64'(acc_cnt[2] - base), 64'd8);

    // parallel paths: one flit per cycle on each
    lat_chk = 1;
    clear_logs();
    add_pkt(0, 1, 4);
    add_pkt(1, 0, 4);
    add_pkt(2, 3, 4);
    drain("par_drain");
    for (int i = 0; i < 3; i++) begin
      span = (acc_cyc[i].size() == 4) ? acc_cyc[i][3] - acc_cyc[i][0] : -1;
      chk($sformatf("par_rate[%0d]", i), 64'(span), 64'd3);
    end

    // randomised traffic with random downstream stalls
    lat_chk = 0;
    rand_rdy = 1;
    for (int n = 0; n < 60; n++)
      add_pkt($urandom_range(0, KN - 1), $urandom_range(0, KN - 1), $urandom_range(1, 4));
    drain("rand_drain");
    rand_rdy = 0;

    // reset in the middle of a packet
    rdy_en[3] = 1'b0;
    base = acc_cnt[0];
    add_pkt(0, 3, 4);
    for (int c = 0; c < 100 && acc_cnt[0] - base < 2; c++) @(posedge clk);
    #2;
    chk("mid_pre_vld", 64'(do_vld[3]), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_do_vld", 64'(do_vld), 64'd0);
    chk("mid_rst_di_rdy", 64'(di_rdy), 64'd0);
    for (int i = 0; i < KN; i++) begin
      inq[i].delete();
      expq[i].delete();
      head_m[i] = 1;
      in_pkt[i] = 0;
      pcnt_m[i] = 0;
    end
    clear_logs();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    rdy_en[3] = 1'b1;
    add_pkt(4, 3, 2);
    drain("post_rst_drain");
    chk("post_rst_owner", 64'(accq_at(3, 0)), 64'd4);

`ifdef CLOS_CM_STAT_EN
    add_pkt(0, 4, 2);
    add_pkt(1, 4, 1);
    add_pkt(2, 4, 3);
    drain("stat_drain");
    chk("pcnt4", 64'(do_pcnt[4]), 64'd3);
    for (int j = 0; j < 4; j++) chk($sformatf("pcnt[%0d]", j), 64'(do_pcnt[j]), 64'(pcnt_m[j]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clos_cm_obuf.md
Name: clos_cm_obuf

Overview:
- Clocked, parametrised central-module (CM) switch for the SDM-Clos router.
- Provides KN input ports and KN output ports, each carrying DW-bit flits with an eof marker. Each output has its own FIFO buffer.
- Wormhole switching: each output runs a round-robin arbiter. A granted input owns that output until its eof flit is accepted.
- Successor to the fixed 5-port unbuffered CM: port count, width and buffer depth are all parameters.

Parameters:
- KN, 5, number of input and output ports.
- DW, 8, flit data width per port.
- DEPTH, 4, per-output FIFO depth; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- di_dat  in  [KN-1:0][DW-1:0]  input flit data.
- di_eof  in  [KN-1:0]  input flit is the last flit of its packet.
- di_vld  in  [KN-1:0]  input flit valid.
- di_rdy  out  [KN-1:0]  input flit accepted this cycle.
- di_dec  in  [KN-1:0][KN-1:0]  one-hot routing request; only meaningful on a head flit.
- do_dat  out  [KN-1:0][DW-1:0]  output flit data.
- do_eof  out  [KN-1:0]  output eof.
- do_vld  out  [KN-1:0]  output valid (FIFO not empty).
- do_rdy  in  [KN-1:0]  downstream accepts the output flit.
- do_pcnt  out  [KN-1:0][15:0]  packet counters; present only with CLOS_CM_STAT_EN.

Behaviour:
- Reset (async, rst_n=0):
  - all FIFOs empty; do_vld=0, do_dat=0, do_eof=0, di_rdy=0;
  - all locks cleared; all RR pointers=0; counters=0.
  - Reset mid-packet discards all in-flight flits and locks.
- Handshake:
  - A transfer occurs when vld and rdy are both high on a clk rising edge.
  - vld must be held until the transfer completes; di_rdy may depend combinationally on di_vld and di_dec.
- Head flit: the first flit after reset or after an eof transfer on that input.
  - Target is the lowest set bit of di_dec[i]; di_dec=0 means no request.
- Locking:
  - Output j holds lock_vld[j] and lock_own[j] (clog2(KN) bits).
  - An input that owns a lock targets the locked output and ignores di_dec.
- Arbitration, per output j, evaluated combinationally each cycle:
  - If locked: grant goes to lock_own[j] only.
  - Else: grant goes to the first requesting head input, searching from rr_ptr[j] upward modulo KN.
  - Grant is suppressed when FIFO j is full.
  - di_rdy[i] = 1 iff input i is granted by its target output.
- State update on a transfer into output j from input i:
  - head with eof=0: lock_vld[j]<=1, lock_own[j]<=i.
  - eof=1: lock_vld[j]<=0.
  - Every head transfer: rr_ptr[j] <= (i+1) mod KN.
  - Single-flit packets (head with eof=1) never lock and still advance rr_ptr.
- Latency: a flit written at edge t is visible on do_* after edge t (one cycle).
- Full output FIFO: no write; the owning input stalls with di_rdy=0; the lock is held.
- Simultaneous read and write when full: the write is still refused (full is computed from the registered count).
- Empty output FIFO: do_vld=0, and do_dat/do_eof hold their last value.
- FIFO pointers wrap at DEPTH.
- Count width is clog2(DEPTH)+1.
- Read and write in the same cycle leave the count unchanged.
- No output can receive from two inputs in one cycle; each input targets at most one output.

Optional Feature:
- Macro: CLOS_CM_STAT_EN.
- Defined:
  - do_pcnt[j] increments on each output transfer with do_eof=1.
  - Saturates at 16'hFFFF; reset to 0.
- Undefined:
  - do_pcnt port and its counters are absent.
  - All other behaviour is identical.

Decomposition:
- Package clos_cm_pkg holds:
  - function clog2;
  - typedef flit_t (struct: dat[DW-1:0], eof), parametrised via the module;
  - localparam PCNT_W=16.
- One sub-module clos_obuf_fifo (DW+1 wide, DEPTH deep, synchronous write/read, async active-low reset), instantiated KN times in a generate loop.
- Arbiter and lock logic stay inline.

Test Plan:
- Single path: KN=5. In0 sends a 3-flit packet to out2 (dec=00100, eof on flit 3), do_rdy=1 → out2 shows the same 3 flits one cycle after each transfer; lock cleared after the eof; rr_ptr[2]=1.
- Contention: in1 and in3 send 2-flit packets to out4 at the same time, rr_ptr=0 → in1 is served entirely first, then in3; no interleaving of flits on do_dat[4].
- Backpressure: do_rdy[0]=0, DEPTH=4, in2 streams to out0 → exactly 4 transfers, then di_rdy[2]=0. Raise do_rdy → 1 flit drains per cycle and the input resumes.
- Parallel paths: in0→out1, in1→out0, in2→out3 all at once → all di_rdy=1 every cycle; no cross-corruption.
- Reset mid-packet: assert rst_n=0 after flit 2 of a 4-flit packet → do_vld=0 and di_rdy=0 immediately. After release, a fresh head from another input to the same output is granted.
- Stats (CLOS_CM_STAT_EN): send 3 packets to out4 → do_pcnt[4]=3; other counters stay 0.
